// File: rtl/rom_arbiter.sv
// Two-master arbiter in front of a single ROM port with a one-cycle request / next-cycle ready handshake.
// A transaction runs IDLE -> WAIT -> RESP; a WAIT that outlasts TIMEOUT cycles completes with an error.
module rom_arbiter #(
   parameter int unsigned TIMEOUT        = 15,
   parameter bit          FIXED_PRIORITY = 1'b0
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_p0_request,
   input  logic        i_p1_request,
   input  logic [31:0] i_p0_address,
   input  logic [31:0] i_p1_address,
   output logic [31:0] o_p0_rdata,
   output logic [31:0] o_p1_rdata,
   output logic        o_p0_ready,
   output logic        o_p1_ready,
   output logic        o_p0_error,
   output logic        o_p1_error,
   output logic        o_rom_request,
   output logic [31:0] o_rom_address,
   input  logic [31:0] i_rom_rdata,
   input  logic        i_rom_ready
);
   localparam logic [7:0] TIMEOUT_COUNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [7:0]       count;
   logic [7:0]       count_next;
   logic             winner;
   logic             winner_next;
   logic             last_grant;
   logic             last_grant_next;
   logic             any_request;
   logic             grant;
   logic             timed_out;
   logic             rom_request;
   logic             rom_request_next;
   logic [31:0]      rom_address;
   logic [31:0]      rom_address_next;
   logic [1:0]       ready;
   logic [1:0]       ready_next;
   logic [1:0]       error;
   logic [1:0]       error_next;
   logic [1:0][31:0] rdata;
   logic [1:0][31:0] rdata_next;

   assign any_request = i_p0_request | i_p1_request;
   assign timed_out   = (count == TIMEOUT_COUNT);

   // A tie goes to the port not granted last, unless port 0 is hard-wired to win.
   always_comb begin
      grant = 1'b0;
      if (i_p0_request && i_p1_request) begin
         grant = FIXED_PRIORITY ? 1'b0 : ~last_grant;
      end else if (i_p1_request) begin
         grant = 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (any_request) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_rom_ready || timed_out) begin
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs; ready/error default low so they only ever pulse.
   always_comb begin
      count_next       = count;
      winner_next      = winner;
      last_grant_next  = last_grant;
      rom_request_next = 1'b0;
      rom_address_next = rom_address;
      ready_next       = 2'b00;
      error_next       = 2'b00;
      rdata_next       = rdata;
      case (state)
         S_IDLE: begin
            if (any_request) begin
               rom_request_next = 1'b1;
               rom_address_next = grant ? i_p1_address : i_p0_address;
               winner_next      = grant;
               last_grant_next  = grant;
               count_next       = 8'd0;
            end
         end
         S_WAIT: begin
            if (i_rom_ready) begin
               rdata_next[winner] = i_rom_rdata;
               ready_next[winner] = 1'b1;
            end else if (timed_out) begin
               rdata_next[winner] = 32'h0000_0000;
               ready_next[winner] = 1'b1;
               error_next[winner] = 1'b1;
            end else begin
               count_next = count + 8'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // After reset port 1 counts as last granted, so port 0 takes the first tie.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count       <= 8'd0;
         winner      <= 1'b0;
         last_grant  <= 1'b1;
         rom_request <= 1'b0;
         rom_address <= 32'h0000_0000;
         ready       <= 2'b00;
         error       <= 2'b00;
         rdata       <= '0;
      end else begin
         count       <= count_next;
         winner      <= winner_next;
         last_grant  <= last_grant_next;
         rom_request <= rom_request_next;
         rom_address <= rom_address_next;
         ready       <= ready_next;
         error       <= error_next;
         rdata       <= rdata_next;
      end
   end

   assign o_rom_request = rom_request;
   assign o_rom_address = rom_address;
   assign o_p0_ready    = ready[0];
   assign o_p1_ready    = ready[1];
   assign o_p0_error    = error[0];
   assign o_p1_error    = error[1];
   assign o_p0_rdata    = rdata[0];
   assign o_p1_rdata    = rdata[1];

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the WAIT-state cycle limit before a forced error completion (1..255).
REQ-002 SHALL have parameter FIXED_PRIORITY, default 0: 0 = round-robin, 1 = port 0 always wins.
REQ-003 SHALL have port i_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports i_p0_request / i_p1_request, input, 1 each, master access requests.
REQ-006 SHALL have ports i_p0_address / i_p1_address, input, 32 each, master byte addresses.
REQ-007 SHALL have ports o_p0_rdata / o_p1_rdata, output, 32 each, registered read data.
REQ-008 SHALL have ports o_p0_ready / o_p1_ready, output, 1 each, one-cycle completion pulses.
REQ-009 SHALL have ports o_p0_error / o_p1_error, output, 1 each, one-cycle timeout pulses coincident with ready.
REQ-010 SHALL have port o_rom_request, output, 1, ROM request.
REQ-011 SHALL have port o_rom_address, output, 32, ROM address.
REQ-012 SHALL have port i_rom_rdata, input, 32, ROM read data.
REQ-013 SHALL have port i_rom_ready, input, 1, ROM completion; ROM returns ready one cycle after a one-cycle request.

Function
REQ-014 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; all outputs are registered.
REQ-015 IDLE: when any i_pX_request is high, the block SHALL select a winner, register its address into o_rom_address, pulse o_rom_request high for exactly one cycle, latch the winner id, clear the timeout counter, and enter WAIT.
REQ-016 Arbitration with FIXED_PRIORITY=0 SHALL grant the requesting port when only one requests, and the port not granted last when both request.
REQ-017 Arbitration with FIXED_PRIORITY=1 SHALL always grant port 0 when both request.
REQ-018 WAIT: o_rom_request SHALL be 0; on i_rom_ready high, the block SHALL copy i_rom_rdata to the winner's o_pX_rdata, pulse the winner's o_pX_ready next cycle, and enter RESP.
REQ-019 WAIT: the timeout counter SHALL increment each cycle without ready; at count == TIMEOUT it SHALL write 32'h00000000 to the winner's rdata, pulse both the winner's ready and error, and enter RESP.
REQ-020 RESP: the block SHALL hold o_pX_ready/o_pX_error high for that cycle only and return to IDLE unconditionally; no new grant is issued in RESP.
REQ-021 The loser's outputs and the non-winner's rdata SHALL remain unchanged through a transaction.
REQ-022 i_rom_ready SHALL be ignored in IDLE and RESP (a late or stray ready has no effect).
REQ-023 Masters hold request and address stable until their ready pulse and drop request the cycle after it; address changes while not granted SHALL have no effect.
REQ-024 Latency SHALL be 3 cycles from request sampled in IDLE to the ready pulse with a 1-cycle ROM; back-to-back throughput is one access per 4 cycles.
REQ-025 The last-granted flag SHALL update only on a grant in IDLE.

Reset
REQ-026 While i_reset_n is low, the block SHALL force state IDLE, o_rom_request=0, o_rom_address=0, all o_pX_ready=0, all o_pX_error=0, all o_pX_rdata=0, timeout counter=0, and last-granted=port 1 (so port 0 wins the first tie).
REQ-027 Reset asserted mid-transaction SHALL abandon it without any ready pulse; a ROM ready arriving after deassertion SHALL be ignored.

Verification
REQ-028 P0 requests addr 0x8 alone, ROM returns 0x11223344 -> o_rom_request pulse 1 cycle with address 0x8; o_p0_ready pulse 3 cycles after the request; o_p0_rdata=0x11223344; port 1 outputs unchanged.
REQ-029 Both request continuously (addr 0x0 / 0x4), FIXED_PRIORITY=0 -> grant order p0, p1, p0, p1; each ready pulse is exactly 1 cycle; grants are 4 cycles apart.
REQ-030 Same stimulus as REQ-029 with FIXED_PRIORITY=1 and p0 re-requesting immediately -> p0 wins every tie.
REQ-031 ROM never readies, TIMEOUT=15 -> the winner receives ready+error together, rdata=0, 1 cycle after count reaches 15; FSM returns to IDLE.
REQ-032 Reset is pulsed in WAIT, then a stray i_rom_ready arrives -> no ready pulse, all outputs 0; the next p1 request completes normally.
REQ-033 i_rom_ready is forced high in IDLE with no requests -> no outputs change.
